fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: next-PC select, IF/ID register, hazard and redirect control
module fetch_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    input  logic [31:0] Instruction,
    input  logic        Hold,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        BranchTaken,
    input  logic        Jump,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    output logic [31:0] NextPC,
    output logic        PCWrite,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        IDEX_Bubble,
    output logic [15:0] FetchCount,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    // One action is chosen per cycle; reset outranks everything else.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_HOLD,
        ACT_STALL,
        ACT_REDIRECT,
        ACT_NORMAL
    } action_t;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [31:0] pc_plus4;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        load_use;
    logic        redirect;
    logic [31:0] redirect_target;
    action_t     action;

    assign pc_plus4 = PCResult + 32'd4;
    assign ifid_rs  = IFID_Instruction[25:21];
    assign ifid_rt  = IFID_Instruction[20:16];

    // Load-use hazard: the EX load writes a register the ID instruction reads.
    // Evaluated purely from current inputs, so a stall lasts exactly as long as the hazard.
    always_comb begin
        load_use = 1'b0;
        if (EX_MemRead && (EX_Rt != 5'd0) && IFID_Valid &&
            ((EX_Rt == ifid_rs) || (EX_Rt == ifid_rt))) begin
            load_use = 1'b1;
        end
    end

    // Redirect request and target; a jump wins over a taken branch.
    always_comb begin
        redirect        = BranchTaken | Jump;
        redirect_target = Jump ? JumpTarget : BranchTarget;
    end

    // Strict-priority action select: Reset > Hold > LoadUse > Redirect > Normal.
    always_comb begin
        action = ACT_NORMAL;
        if (Reset) begin
            action = ACT_RESET;
        end else if (Hold) begin
            action = ACT_HOLD;
        end else if (load_use) begin
            action = ACT_STALL;
        end else if (redirect) begin
            action = ACT_REDIRECT;
        end
    end

    // PC-register controls and ID/EX bubble request for the chosen action.
    always_comb begin
        NextPC      = pc_plus4;
        PCWrite     = 1'b0;
        IDEX_Bubble = 1'b0;
        case (action)
            ACT_STALL: begin
                IDEX_Bubble = 1'b1;
            end
            ACT_REDIRECT: begin
                NextPC  = redirect_target;
                PCWrite = 1'b1;
            end
            ACT_NORMAL: begin
                PCWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // IF/ID pipeline register: load on a normal fetch, clear on a redirect, otherwise keep.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            IFID_Instruction <= 32'd0;
            IFID_PCPlus4     <= 32'd0;
            IFID_Valid       <= 1'b0;
        end else begin
            case (action)
                ACT_REDIRECT: begin
                    IFID_Instruction <= 32'd0;
                    IFID_PCPlus4     <= 32'd0;
                    IFID_Valid       <= 1'b0;
                end
                ACT_NORMAL: begin
                    IFID_Instruction <= Instruction;
                    IFID_PCPlus4     <= pc_plus4;
                    IFID_Valid       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating performance counters, one bumped per fetch, stall or flush cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FetchCount <= 16'd0;
            StallCount <= 16'd0;
            FlushCount <= 16'd0;
        end else begin
            case (action)
                ACT_STALL: begin
                    if (StallCount != COUNT_MAX) begin
                        StallCount <= StallCount + 16'd1;
                    end
                end
                ACT_REDIRECT: begin
                    if (FlushCount != COUNT_MAX) begin
                        FlushCount <= FlushCount + 16'd1;
                    end
                end
                ACT_NORMAL: begin
                    if (FetchCount != COUNT_MAX) begin
                        FetchCount <= FetchCount + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
